// File: rtl/cmp_scan_pkg.sv
// -----------------------------------------------------------------------------
// cmp_scan_pkg
// Shared types and defaults for the comparator-scan SAR converter.
//   state_t  : sequencer states (IDLE, PICK, SEL, BIT, DONE)
//   DEF_*    : default channel count, DAC width and settle-count width
//   SYNC_STG : depth of the COMP_O synchronizer
// -----------------------------------------------------------------------------
package cmp_scan_pkg;

  localparam int DEF_N_CH = 16;
  localparam int DEF_DACW = 10;
  localparam int DEF_STLW = 4;
  localparam int SYNC_STG = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    SEL  = 3'd2,
    BIT  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/cmp_rr_pick.sv
// -----------------------------------------------------------------------------
// cmp_rr_pick
// Combinational round-robin finder: returns the lowest enabled channel index
// strictly above ptr, wrapping through 0 and ending at ptr itself (so a single
// enabled channel equal to ptr is found again).
//   mask  in  N_CH  channel enable mask
//   ptr   in  CHW   index of the last channel served
//   idx   out CHW   next channel to serve (0 when none found)
//   found out 1     at least one channel is enabled
// -----------------------------------------------------------------------------
module cmp_rr_pick #(
  parameter int N_CH = 16,
  parameter int CHW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CHW-1:0]  ptr,
  output logic [CHW-1:0]  idx,
  output logic            found
);

  logic [CHW-1:0] pos;

  // Walk the mask starting one above the pointer; first hit wins.
  always_comb begin
    idx   = {CHW{1'b0}};
    found = 1'b0;
    pos   = {CHW{1'b0}};
    for (int i = 1; i <= N_CH; i++) begin
      pos = CHW'((int'(ptr) + i) % N_CH);
      if (!found && mask[pos]) begin
        idx   = pos;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/cmp_scan_sar.sv
// -----------------------------------------------------------------------------
// cmp_scan_sar
// Round-robin SAR sequencer for the shared analog comparator. Each enabled
// channel is selected on the comparator mux, the sample/hold is reset for a
// settle period, then DACW successive-approximation trials are run on DAC1.
// One result strobe is produced per channel.
//   clk, srstz         clock and synchronous active-low reset
//   scan_en, ch_en     scan enable and per-channel enable mask
//   settle_cyc         extra settle cycles after each mux/DAC change
//   cmp_o              raw asynchronous comparator output
//   cmp_sel            one-hot comparator mux select
//   dac1, dac1_en      DAC1 trial code and enable
//   ad_rst, ad_hold    sample/hold reset and hold
//   busy               high in every state except IDLE
//   res_vld/ch/dat     one-cycle result strobe, channel index, code
// All outputs are registered and aligned with the state register.
// -----------------------------------------------------------------------------
module cmp_scan_sar
  import cmp_scan_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int DACW = DEF_DACW,
  parameter int STLW = DEF_STLW
) (
  input  logic                    clk,
  input  logic                    srstz,
  input  logic                    scan_en,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [STLW-1:0]         settle_cyc,
  input  logic                    cmp_o,
  output logic [N_CH-1:0]         cmp_sel,
  output logic [DACW-1:0]         dac1,
  output logic                    dac1_en,
  output logic                    ad_rst,
  output logic                    ad_hold,
  output logic                    busy,
  output logic                    res_vld,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic [DACW-1:0]         res_dat
);

  localparam int CHW  = $clog2(N_CH);
  localparam int BW   = (DACW > 1) ? $clog2(DACW) : 1;
  // Must hold settle_cyc + 2 at its maximum.
  localparam int CNTW = STLW + 2;

  // Single set bit at position b of the DAC word.
  function automatic logic [DACW-1:0] dac_bit(input logic [BW-1:0] b);
    dac_bit = {{(DACW-1){1'b0}}, 1'b1} << b;
  endfunction

  // One-hot mux select for channel c.
  function automatic logic [N_CH-1:0] ch_onehot(input logic [CHW-1:0] c);
    ch_onehot = {{(N_CH-1){1'b0}}, 1'b1} << c;
  endfunction

  state_t              state_r, state_s;
  logic [CHW-1:0]      ptr_r, ptr_s;
  logic [CHW-1:0]      ch_r, ch_s;
  logic [DACW-1:0]     acc_r, acc_s;
  logic [BW-1:0]       bit_r, bit_s;
  logic [CNTW-1:0]     cnt_r, cnt_s;

  logic [N_CH-1:0]     cmp_sel_r, cmp_sel_s;
  logic [DACW-1:0]     dac1_r, dac1_s;
  logic                dac1_en_r, dac1_en_s;
  logic                ad_rst_r, ad_rst_s;
  logic                ad_hold_r, ad_hold_s;
  logic                busy_r;
  logic                res_vld_r, res_vld_s;
  logic [CHW-1:0]      res_ch_r, res_ch_s;
  logic [DACW-1:0]     res_dat_r, res_dat_s;

  logic [SYNC_STG-1:0] sync_r;
  logic                cmp_s;

  logic [CHW-1:0]      pick_idx_s;
  logic                pick_found_s;
  logic [CNTW-1:0]     settle_ext_s;
  logic                sel_end_s;
  logic                bit_end_s;
  logic [CNTW-1:0]     cnt_inc_s;
  logic [DACW-1:0]     acc_upd_s;
  logic [BW-1:0]       bit_dec_s;

  cmp_rr_pick #(
    .N_CH (N_CH),
    .CHW  (CHW)
  ) u_pick (
    .mask  (ch_en),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (!srstz) begin
      sync_r <= {SYNC_STG{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], cmp_o};
    end
  end

  assign cmp_s = sync_r[SYNC_STG-1];

  // Settle/trial counters: SEL ends at cnt==settle, a trial bit ends at
  // cnt==settle+2 so the comparator decision has crossed the synchronizer.
  assign settle_ext_s = {{(CNTW-STLW){1'b0}}, settle_cyc};
  assign sel_end_s    = (cnt_r == settle_ext_s);
  assign bit_end_s    = (cnt_r == (settle_ext_s + {{(CNTW-2){1'b0}}, 2'd2}));
  assign cnt_inc_s    = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
  assign acc_upd_s    = cmp_s ? (acc_r | dac_bit(bit_r)) : acc_r;
  assign bit_dec_s    = bit_r - {{(BW-1){1'b0}}, 1'b1};

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    ch_s      = ch_r;
    acc_s     = acc_r;
    bit_s     = bit_r;
    cnt_s     = cnt_r;
    cmp_sel_s = cmp_sel_r;
    dac1_s    = dac1_r;
    dac1_en_s = dac1_en_r;
    ad_rst_s  = ad_rst_r;
    ad_hold_s = ad_hold_r;
    res_vld_s = 1'b0;
    res_ch_s  = res_ch_r;
    res_dat_s = res_dat_r;

    case (state_r)
      IDLE: begin
        if (scan_en && pick_found_s) begin
          state_s = PICK;
        end else begin
          state_s = IDLE;
        end
      end

      PICK: begin
        if (scan_en && pick_found_s) begin
          ptr_s     = pick_idx_s;
          ch_s      = pick_idx_s;
          cmp_sel_s = ch_onehot(pick_idx_s);
          dac1_en_s = 1'b1;
          dac1_s    = {DACW{1'b0}};
          ad_rst_s  = 1'b1;
          ad_hold_s = 1'b0;
          acc_s     = {DACW{1'b0}};
          cnt_s     = {CNTW{1'b0}};
          state_s   = SEL;
        end else begin
          // Scan stopped or mask emptied: park with every output at reset value.
          state_s   = IDLE;
          cmp_sel_s = {N_CH{1'b0}};
          dac1_s    = {DACW{1'b0}};
          dac1_en_s = 1'b0;
          ad_rst_s  = 1'b1;
          ad_hold_s = 1'b0;
          res_ch_s  = {CHW{1'b0}};
          res_dat_s = {DACW{1'b0}};
        end
      end

      SEL: begin
        if (sel_end_s) begin
          ad_rst_s  = 1'b0;
          ad_hold_s = 1'b1;
          bit_s     = BW'(DACW - 1);
          cnt_s     = {CNTW{1'b0}};
          dac1_s    = acc_r | dac_bit(BW'(DACW - 1));
          state_s   = BIT;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      BIT: begin
        if (bit_end_s) begin
          acc_s = acc_upd_s;
          cnt_s = {CNTW{1'b0}};
          if (bit_r == {BW{1'b0}}) begin
            res_vld_s = 1'b1;
            res_ch_s  = ch_r;
            res_dat_s = acc_upd_s;
            ad_hold_s = 1'b0;
            state_s   = DONE;
          end else begin
            // Next trial keeps the decided bits and sets the next one down.
            bit_s  = bit_dec_s;
            dac1_s = acc_upd_s | dac_bit(bit_dec_s);
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      DONE: begin
        state_s = PICK;
      end

      default: begin
        state_s   = IDLE;
        cmp_sel_s = {N_CH{1'b0}};
        dac1_s    = {DACW{1'b0}};
        dac1_en_s = 1'b0;
        ad_rst_s  = 1'b1;
        ad_hold_s = 1'b0;
        res_ch_s  = {CHW{1'b0}};
        res_dat_s = {DACW{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs; pointer resets so channel 0 goes first.
  always_ff @(posedge clk) begin
    if (!srstz) begin
      state_r   <= IDLE;
      ptr_r     <= CHW'(N_CH - 1);
      ch_r      <= {CHW{1'b0}};
      acc_r     <= {DACW{1'b0}};
      bit_r     <= {BW{1'b0}};
      cnt_r     <= {CNTW{1'b0}};
      cmp_sel_r <= {N_CH{1'b0}};
      dac1_r    <= {DACW{1'b0}};
      dac1_en_r <= 1'b0;
      ad_rst_r  <= 1'b1;
      ad_hold_r <= 1'b0;
      busy_r    <= 1'b0;
      res_vld_r <= 1'b0;
      res_ch_r  <= {CHW{1'b0}};
      res_dat_r <= {DACW{1'b0}};
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      ch_r      <= ch_s;
      acc_r     <= acc_s;
      bit_r     <= bit_s;
      cnt_r     <= cnt_s;
      cmp_sel_r <= cmp_sel_s;
      dac1_r    <= dac1_s;
      dac1_en_r <= dac1_en_s;
      ad_rst_r  <= ad_rst_s;
      ad_hold_r <= ad_hold_s;
      busy_r    <= (state_s != IDLE);
      res_vld_r <= res_vld_s;
      res_ch_r  <= res_ch_s;
      res_dat_r <= res_dat_s;
    end
  end

  assign cmp_sel = cmp_sel_r;
  assign dac1    = dac1_r;
  assign dac1_en = dac1_en_r;
  assign ad_rst  = ad_rst_r;
  assign ad_hold = ad_hold_r;
  assign busy    = busy_r;
  assign res_vld = res_vld_r;
  assign res_ch  = res_ch_r;
  assign res_dat = res_dat_r;

endmodule
